// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: controller state encodings, frame constants and parity helper.
// Used by both the host transmitter and the receiver.
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RTS,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_ACK
    } ps2_state_t;

    localparam int   PS2_DATA_W    = 8;
    localparam int   PS2_PAYLOAD_W = 9;     // data byte plus parity
    localparam logic PS2_START_BIT = 1'b0;
    localparam logic PS2_STOP_BIT  = 1'b1;

    function automatic logic odd_parity(input logic [PS2_DATA_W-1:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_tx_if.sv
// Host-side command interface of the PS/2 transmitter: write strobe, byte, status ticks.
interface ps2_tx_if;
    import ps2_pkg::*;

    logic                  wr_ps2;
    logic [PS2_DATA_W-1:0] din;
    logic                  tx_idle;
    logic                  tx_done_tick;
    logic                  tx_err_tick;

    modport master (
        output wr_ps2, din,
        input  tx_idle, tx_done_tick, tx_err_tick
    );

    modport slave (
        input  wr_ps2, din,
        output tx_idle, tx_done_tick, tx_err_tick
    );

endinterface

// File: rtl/ps2_clk_filter.sv
// PS/2 clock deglitcher: the filtered level only moves after 8 identical samples,
// and fall_edge pulses for one cycle on the filtered 1->0 transition.
module ps2_clk_filter (
    input  logic clk,
    input  logic reset,
    input  logic ps2c_in,
    output logic fall_edge
);

    logic [7:0] filt_q;
    logic       level_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            filt_q  <= 8'hFF;
            level_q <= 1'b1;
        end else begin
            filt_q <= {ps2c_in, filt_q[7:1]};
            if (filt_q == 8'hFF)
                level_q <= 1'b1;
            else if (filt_q == 8'h00)
                level_q <= 1'b0;
        end
    end

    // True only in the single cycle before level_q follows an all-zero window.
    assign fall_edge = level_q && (filt_q == 8'h00);

endmodule

// File: rtl/ps2_tx.sv
// PS/2 host-to-device transmitter: clock inhibit (RTS), start bit, 8 data bits,
// odd parity, stop bit and device acknowledge, with a whole-frame timeout abort.
module ps2_tx
    import ps2_pkg::*;
#(
    parameter int RTS_CYCLES     = 5000,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic     clk,
    input  logic     reset,
    ps2_tx_if.slave  bus,
    inout  wire      ps2c,
    inout  wire      ps2d
);

    localparam int RTS_W = (RTS_CYCLES > 1) ? $clog2(RTS_CYCLES) : 1;
    localparam int TO_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam int BIT_W = $clog2(PS2_PAYLOAD_W);

    ps2_state_t               state_q, state_d;
    logic [PS2_PAYLOAD_W-1:0] sh_q, sh_d;
    logic [BIT_W-1:0]         n_q, n_d;
    logic [RTS_W-1:0]         rts_q, rts_d;
    logic [TO_W-1:0]          frame_q, frame_d;

    logic fall_edge;
    logic timeout;
    logic c_low, d_low;
    logic idle, done, err;

    ps2_clk_filter u_filter (
        .clk       (clk),
        .reset     (reset),
        .ps2c_in   (ps2c),
        .fall_edge (fall_edge)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            sh_q    <= '0;
            n_q     <= '0;
            rts_q   <= '0;
            frame_q <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            n_q     <= n_d;
            rts_q   <= rts_d;
            frame_q <= frame_d;
        end
    end

    // The frame counter runs from acceptance; its last value is the final frame cycle.
    assign timeout = (state_q != ST_IDLE) && (frame_q == TO_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        n_d     = n_q;
        rts_d   = rts_q;
        frame_d = frame_q + 1'b1;
        c_low   = 1'b0;
        d_low   = 1'b0;
        idle    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                idle    = 1'b1;
                frame_d = '0;
                if (bus.wr_ps2) begin
                    sh_d    = {odd_parity(bus.din), bus.din};
                    rts_d   = RTS_W'(RTS_CYCLES - 1);
                    state_d = ST_RTS;
                end
            end
            ST_RTS: begin
                c_low = 1'b1;
                if (rts_q == '0)
                    state_d = ST_START;
                else
                    rts_d = rts_q - 1'b1;
            end
            ST_START: begin
                d_low = ~PS2_START_BIT;
                if (fall_edge) begin
                    n_d     = BIT_W'(PS2_PAYLOAD_W - 1);
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                d_low = ~sh_q[0];
                if (fall_edge) begin
                    if (n_q == '0) begin
                        state_d = ST_STOP;
                    end else begin
                        sh_d = sh_q >> 1;
                        n_d  = n_q - 1'b1;
                    end
                end
            end
            ST_STOP: begin
                d_low = ~PS2_STOP_BIT;
                if (fall_edge)
                    state_d = ST_ACK;
            end
            ST_ACK: begin
                // A missing acknowledge (ps2d high) still completes: no retry.
                if (fall_edge) begin
                    done    = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (timeout) begin
            state_d = ST_IDLE;
            c_low   = 1'b0;
            d_low   = 1'b0;
            done    = 1'b0;
            err     = 1'b1;
        end
    end

    assign ps2c = c_low ? 1'b0 : 1'bz;
    assign ps2d = d_low ? 1'b0 : 1'bz;

    assign bus.tx_idle      = idle;
    assign bus.tx_done_tick = done;
    assign bus.tx_err_tick  = err;

endmodule

// File: tb/tb_ps2_tx.sv
// Directed bench for ps2_tx: a PS/2 device model clocks frames out of the host and
// checks wire bits, inhibit length, ticks, timeout, glitch rejection and reset abort.
module tb_ps2_tx;

    localparam int RTS = 20;
    localparam int TO  = 2000;
    localparam int HP  = 20;    // device clock half period in clk cycles

    logic clk;
    logic reset;
    logic dev_c_low;
    logic dev_d_low;
    wire  ps2c;
    wire  ps2d;

    int checks;
    int errors;
    int done_cnt;
    int err_cnt;
    int clow_cnt;

    ps2_tx_if bus ();

    ps2_tx #(
        .RTS_CYCLES     (RTS),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus),
        .ps2c  (ps2c),
        .ps2d  (ps2d)
    );

    pullup (ps2c);
    pullup (ps2d);
    assign ps2c = dev_c_low ? 1'b0 : 1'bz;
    assign ps2d = dev_d_low ? 1'b0 : 1'bz;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.tx_done_tick === 1'b1) done_cnt++;
        if (bus.tx_err_tick === 1'b1) err_cnt++;
        if (ps2c === 1'b0 && !dev_c_low) clow_cnt++;
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        chk("idle_before_wr", bus.tx_idle, 1'b1);
        bus.din    = b;
        bus.wr_ps2 = 1'b1;
        @(negedge clk);
        bus.wr_ps2 = 1'b0;
        chk("idle_after_accept", bus.tx_idle, 1'b0);
    endtask

    task automatic wait_start();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 200 && !found; k++) begin
            @(negedge clk);
            if (bus.tx_idle === 1'b0 && ps2c === 1'b1 && ps2d === 1'b0) found = 1'b1;
        end
        chk("start_seen", found, 1'b1);
        repeat (15) @(negedge clk);     // let the clock filter see the released line
    endtask

    // Device clocks start..stop (11 falls incl. the one that ends START) plus the acknowledge fall.
    task automatic dev_frame(input bit ack_low, input bit glitch, input bit inject,
                             output logic [10:0] bits);
        bits = '0;
        wait_start();
        if (glitch) begin
            dev_c_low = 1'b1;
            repeat (3) @(negedge clk);
            dev_c_low = 1'b0;
            repeat (15) @(negedge clk);
            chk("glitch_hold", {14'd0, ps2d, bus.tx_idle}, 16'h0000);
        end
        bits[0] = ps2d;
        for (int i = 1; i <= 11; i++) begin
            dev_c_low = 1'b1;
            if (inject && i == 3) begin
                bus.din    = 8'h55;
                bus.wr_ps2 = 1'b1;
                @(negedge clk);
                bus.wr_ps2 = 1'b0;
                repeat (HP - 1) @(negedge clk);
            end else begin
                repeat (HP) @(negedge clk);
            end
            if (i <= 10) bits[i] = ps2d;
            dev_c_low = 1'b0;
            repeat (HP) @(negedge clk);
        end
        dev_d_low = ack_low;
        repeat (4) @(negedge clk);
        dev_c_low = 1'b1;
        repeat (HP) @(negedge clk);
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        repeat (HP) @(negedge clk);
    endtask

    task automatic full_frame(input string tag, input logic [7:0] b, input logic [10:0] exp_bits,
                              input bit ack_low, input bit glitch, input bit inject);
        logic [10:0] bits;
        int d0, e0, c0;
        d0 = done_cnt;
        e0 = err_cnt;
        c0 = clow_cnt;
        send(b);
        dev_frame(ack_low, glitch, inject, bits);
        repeat (5) @(negedge clk);
        chk({tag, "_bits"}, {5'd0, bits}, {5'd0, exp_bits});
        chk({tag, "_rts_len"}, 16'(clow_cnt - c0), 16'(RTS));
        chk({tag, "_done"}, 16'(done_cnt - d0), 16'd1);
        chk({tag, "_err"}, 16'(err_cnt - e0), 16'd0);
        chk({tag, "_idle_lines"}, {13'd0, bus.tx_idle, ps2c, ps2d}, 16'h0007);
    endtask

    initial begin
        logic [15:0] lines_at;
        logic        done_at;
        int          hit;
        int          d0, e0;
        bit          found;

        checks    = 0;
        errors    = 0;
        done_cnt  = 0;
        err_cnt   = 0;
        clow_cnt  = 0;
        dev_c_low = 1'b0;
        dev_d_low = 1'b0;
        bus.wr_ps2 = 1'b0;
        bus.din    = 8'h00;
        reset      = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_outputs", {13'd0, bus.tx_idle, bus.tx_done_tick, bus.tx_err_tick}, 16'h0004);
        chk("reset_lines", {14'd0, ps2c, ps2d}, 16'h0003);
        reset = 1'b0;
        repeat (3) @(negedge clk);

        // 0xED: data 1,0,1,1,0,1,1,1 parity 1 -> {stop,par,data,start} = 0x7DA
        full_frame("ed", 8'hED, 11'h7DA, 1'b1, 1'b0, 1'b0);
        // 0x01 parity 0 -> 0x402, with a 3-cycle clock glitch during START
        full_frame("01_glitch", 8'h01, 11'h402, 1'b1, 1'b1, 1'b0);
        // 0x00 parity 1 -> 0x600, device leaves data high at acknowledge
        full_frame("00_nack", 8'h00, 11'h600, 1'b0, 1'b0, 1'b0);
        // 0xFF parity 1 -> 0x7FE
        full_frame("ff", 8'hFF, 11'h7FE, 1'b1, 1'b0, 1'b0);
        // 0xF4 parity 0 -> 0x5E8, stray write of 0x55 while bits are shifting
        full_frame("f4_inject", 8'hF4, 11'h5E8, 1'b1, 1'b0, 1'b1);
        repeat (100) @(negedge clk);
        chk("inject_no_new_frame", {14'd0, bus.tx_idle, ps2c}, 16'h0003);

        // Timeout: nobody clocks, error tick lands TO cycles after the write cycle
        d0 = done_cnt;
        e0 = err_cnt;
        send(8'h12);
        found    = 1'b0;
        hit      = 0;
        lines_at = 16'hFFFF;
        done_at  = 1'b1;
        for (int n = 2; n <= TO + 50 && !found; n++) begin
            @(negedge clk);
            if (bus.tx_err_tick === 1'b1) begin
                found    = 1'b1;
                hit      = n;
                done_at  = bus.tx_done_tick;
                lines_at = {14'd0, ps2c, ps2d};
            end
        end
        chk("to_seen", found, 1'b1);
        chk("to_cycle", 16'(hit), 16'(TO));
        chk("to_no_done", done_at, 1'b0);
        chk("to_lines", lines_at, 16'h0003);
        @(negedge clk);
        chk("to_idle_next", {13'd0, bus.tx_idle, ps2c, ps2d}, 16'h0007);
        chk("to_tick_counts", {8'(done_cnt - d0), 8'(err_cnt - e0)}, 16'h0001);

        // Reset while bits of 0x00 are on the wire
        send(8'h00);
        wait_start();
        for (int i = 1; i <= 3; i++) begin
            dev_c_low = 1'b1;
            repeat (HP) @(negedge clk);
            dev_c_low = 1'b0;
            repeat (HP) @(negedge clk);
        end
        chk("pre_reset_data_low", {15'd0, ps2d}, 16'h0000);
        d0 = done_cnt;
        e0 = err_cnt;
        @(negedge clk);
        #1 reset = 1'b1;
        #1;
        chk("reset_async_lines", {13'd0, bus.tx_idle, ps2c, ps2d}, 16'h0007);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        chk("reset_no_ticks", {8'(done_cnt - d0), 8'(err_cnt - e0)}, 16'h0000);
        full_frame("ed_after_reset", 8'hED, 11'h7DA, 1'b1, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
